// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen -- camera-style test pattern source (OV76xx-like parallel bus).
//
// Produces PCLK/VSYNC/HREF/D framing from a single master clock. One byte slot
// lasts PCLK_DIV MCLK cycles; all framing outputs move only on the PCLK falling
// edge (slot boundary). Pattern mode and fixed value are latched at frame start.
//
// Optional feature: define CAMGEN_PRBS_EN to make mode 3 emit a PRBS8 sequence
// (x^8+x^6+x^5+x^4+1, seed 0xFF at every VSYNC entry) instead of ipFixVal.
//
// Ports:
//   xipMCLK      in   master clock, everything on its rising edge
//   xinRESET     in   synchronous active-low reset
//   ipEnable     in   run request (sampled at frame boundaries)
//   ipMode       in   2  pattern: 0 ramp, 1 line index, 2 checker, 3 fixed/PRBS
//   ipFixVal     in   8  byte used by mode 3 (non-PRBS build)
//   xopCAM_PCLK  out  pixel clock
//   xopCAM_VSYNC out  high during the VSYNC period
//   xopCAM_HREF  out  high during active bytes of an active line
//   xopCAM_D     out  8  pixel byte, 0x00 outside HREF
//   opBusy       out  high whenever a frame is in progress
//   opFrameDone  out  one-MCLK pulse at the end of each frame
//   opFrameCnt   out  16 completed-frame counter (wraps)
module cam_pattern_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned BPP         = 2,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned PCLK_DIV    = 2
) (
  input  logic        xipMCLK,
  input  logic        xinRESET,
  input  logic        ipEnable,
  input  logic [1:0]  ipMode,
  input  logic [7:0]  ipFixVal,
  output logic        xopCAM_PCLK,
  output logic        xopCAM_VSYNC,
  output logic        xopCAM_HREF,
  output logic [7:0]  xopCAM_D,
  output logic        opBusy,
  output logic        opFrameDone,
  output logic [15:0] opFrameCnt
);

  localparam logic [15:0] ACT_BYTES = 16'(H_ACTIVE * BPP);
  localparam logic [15:0] SLOT_LAST = 16'(H_ACTIVE * BPP + H_BLANK - 1);
  localparam logic [7:0]  DIV_LAST  = 8'(PCLK_DIV - 1);
  localparam logic [7:0]  DIV_HALF  = 8'(PCLK_DIV / 2);
  localparam logic [2:0]  BSUB_LAST = 3'(BPP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] slot_q, slot_d;   // byte slot within the current line
  logic [15:0] line_q, line_d;   // line within the current period
  logic [15:0] pix_q, pix_d;     // pixel index within the line
  logic [2:0]  bsub_q, bsub_d;   // byte within the current pixel
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  fix_q, fix_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic [15:0] cnt_q, cnt_d;

  logic        tick;
  logic        line_end;
  logic        period_end;
  logic        frame_start;
  logic [15:0] period_last;
  logic [7:0]  pat;

`ifdef CAMGEN_PRBS_EN
  logic [7:0]  lfsr_q, lfsr_d;
`endif

  assign tick        = (div_q == DIV_LAST);
  assign div_d       = tick ? '0 : div_q + 8'd1;
  assign line_end    = (slot_q == SLOT_LAST);
  assign period_end  = line_end && (line_q == period_last);

  assign xopCAM_PCLK  = (div_q >= DIV_HALF);
  assign xopCAM_VSYNC = vsync_q;
  assign xopCAM_HREF  = href_q;
  assign xopCAM_D     = data_q;
  assign opBusy       = (state_q != ST_IDLE);
  assign opFrameDone  = done_q;
  assign opFrameCnt   = cnt_q;

  always_comb begin
    period_last = '0;
    case (state_q)
      ST_VSYNC:  period_last = 16'(VSYNC_LINES - 1);
      ST_VBACK:  period_last = 16'(V_BACK - 1);
      ST_ACTIVE: period_last = 16'(V_ACTIVE - 1);
      ST_VFRONT: period_last = 16'(V_FRONT - 1);
      default:   period_last = '0;
    endcase
  end

  // Position counters advance at every slot boundary; the outputs for the
  // coming slot are derived from the next-state position so that VSYNC/HREF/D
  // line up exactly with the state they describe.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    line_d      = line_q;
    pix_d       = pix_q;
    bsub_d      = bsub_q;
    mode_d      = mode_q;
    fix_d       = fix_q;
    vsync_d     = vsync_q;
    href_d      = href_q;
    data_d      = data_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    frame_start = 1'b0;
    pat         = '0;

    if (tick) begin
      slot_d = line_end ? '0 : slot_q + 16'd1;
      if (line_end) begin
        pix_d  = '0;
        bsub_d = '0;
        line_d = period_end ? '0 : line_q + 16'd1;
      end else if (bsub_q == BSUB_LAST) begin
        pix_d  = pix_q + 16'd1;
        bsub_d = '0;
      end else begin
        bsub_d = bsub_q + 3'd1;
      end

      case (state_q)
        ST_IDLE: begin
          slot_d = '0;
          line_d = '0;
          pix_d  = '0;
          bsub_d = '0;
          if (ipEnable) begin
            state_d     = ST_VSYNC;
            frame_start = 1'b1;
          end
        end
        ST_VSYNC:  if (period_end) state_d = ST_VBACK;
        ST_VBACK:  if (period_end) state_d = ST_ACTIVE;
        ST_ACTIVE: if (period_end) state_d = ST_VFRONT;
        ST_VFRONT: begin
          if (period_end) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + 16'd1;
            if (ipEnable) begin
              state_d     = ST_VSYNC;
              frame_start = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (frame_start) begin
        mode_d = ipMode;
        fix_d  = ipFixVal;
      end

      case (mode_q)
        2'd0: pat = slot_d[7:0];
        2'd1: pat = line_d[7:0];
        2'd2: pat = {8{pix_d[0] ^ line_d[0]}};
`ifdef CAMGEN_PRBS_EN
        default: pat = lfsr_q;
`else
        default: pat = fix_q;
`endif
      endcase

      vsync_d = (state_d == ST_VSYNC);
      href_d  = (state_d == ST_ACTIVE) && (slot_d < ACT_BYTES);
      data_d  = href_d ? pat : '0;
    end
  end

`ifdef CAMGEN_PRBS_EN
  // Fibonacci PRBS8, taps 8,6,5,4; the current value is emitted, then stepped.
  always_comb begin
    lfsr_d = lfsr_q;
    if (tick) begin
      if (frame_start) begin
        lfsr_d = 8'hFF;
      end else if (href_d) begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
    end
  end

  always_ff @(posedge xipMCLK) begin
    if (!xinRESET) begin
      lfsr_q <= 8'hFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  always_ff @(posedge xipMCLK) begin
    if (!xinRESET) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      slot_q  <= '0;
      line_q  <= '0;
      pix_q   <= '0;
      bsub_q  <= '0;
      mode_q  <= '0;
      fix_q   <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      slot_q  <= slot_d;
      line_q  <= line_d;
      pix_q   <= pix_d;
      bsub_q  <= bsub_d;
      mode_q  <= mode_d;
      fix_q   <= fix_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
